uart_pixel_loader: RTL and testbench

UART_PIXEL_LOADER -- requirements
Module: uart_pixel_loader

---
 rtl/uart_pixel_loader_pkg.sv | 25 ++
 rtl/uart_pixel_loader_if.sv | 34 +++
 rtl/uart_pixel_loader_inactivity_timer.sv | 39 +++
 rtl/uart_pixel_loader.sv | 136 +++++++++++++
 tb/tb_uart_pixel_loader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pixel_loader_pkg.sv
// Shared definitions for the UART pixel loader and the downstream Sobel stage:
// loader state encoding, image geometry defaults and address-width helpers.
package uart_pixel_loader_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          DEF_IMG_W     = 64;
    localparam int          DEF_IMG_H     = 64;
    localparam logic [7:0]  DEF_SYNC_BYTE = 8'hAA;

    // clog2 that never returns 0, so a 1-pixel dimension still gets a 1-bit field
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pixel-buffer address width for a w x h image
    function automatic int addr_w(input int w, input int h);
        return clog2_min1(w * h);
    endfunction

endpackage

// File: rtl/uart_pixel_loader_if.sv
// Byte-in / pixel-write-out signal bundle of the loader. The loader uses the
// slave view; whoever feeds bytes and consumes the buffer writes uses master.
interface uart_pixel_loader_if
    import uart_pixel_loader_pkg::*;
#(
    parameter int ADDR_W = addr_w(DEF_IMG_W, DEF_IMG_H),
    parameter int RW_W   = clog2_min1(DEF_IMG_H),
    parameter int CW_W   = clog2_min1(DEF_IMG_W)
);
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              frame_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [RW_W-1:0]   row;
    logic [CW_W-1:0]   col;
    logic              busy;
    logic              frame_ready;
    logic              err_timeout;
    logic              err_overrun;

    modport slave (
        input  rx_byte, rx_valid, frame_ack,
        output wr_en, wr_addr, wr_data, row, col,
        output busy, frame_ready, err_timeout, err_overrun
    );

    modport master (
        output rx_byte, rx_valid, frame_ack,
        input  wr_en, wr_addr, wr_data, row, col,
        input  busy, frame_ready, err_timeout, err_overrun
    );
endinterface

// File: rtl/uart_pixel_loader_inactivity_timer.sv
// Inactivity counter: counts enabled cycles since the last clear and pulses
// expire for one cycle when TIMEOUT cycles have elapsed. clear has priority,
// so an expiry coinciding with a clear never fires.
module inactivity_timer #(
    parameter int TIMEOUT = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count and expiry strobe
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                expire = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_pixel_loader.sv
// Loads one image frame from a UART byte stream into a pixel buffer: waits for
// a sync byte, writes IMG_W*IMG_H pixels in raster order, then holds the frame
// until the consumer acknowledges it. Aborts a frame after TIMEOUT idle cycles.
module uart_pixel_loader
    import uart_pixel_loader_pkg::*;
#(
    parameter int         IMG_W     = DEF_IMG_W,
    parameter int         IMG_H     = DEF_IMG_H,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         TIMEOUT   = 100_000
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_pixel_loader_if.slave  bus
);
    localparam int ADDR_W = addr_w(IMG_W, IMG_H);
    localparam int RW_W   = clog2_min1(IMG_H);
    localparam int CW_W   = clog2_min1(IMG_W);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CW_W-1:0]   LAST_COL  = CW_W'(IMG_W - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RW_W-1:0]   row_q, row_d;
    logic [CW_W-1:0]   col_q, col_d;
    logic              rx_valid_prev_q;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;
    logic              accept;
    logic              expire;

    // Rising edge of the receive strobe: a held strobe counts as one byte
    assign accept = bus.rx_valid & ~rx_valid_prev_q;

    inactivity_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state_q == S_LOAD),
        .expire (expire)
    );

    // Next-state, address walk and registered-output decode
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        row_d         = row_q;
        col_d         = col_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (accept && bus.rx_byte == SYNC_BYTE) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = bus.rx_byte;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        addr_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + RW_W'(1);
                        end else begin
                            col_d = col_q + CW_W'(1);
                        end
                    end
                end else if (expire) begin
                    state_d       = S_SYNC;
                    err_timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                // A byte arriving with the ack is an overrun, never a sync byte
                if (accept)        err_overrun_d = 1'b1;
                if (bus.frame_ack) state_d       = S_SYNC;
            end
            default: state_d = S_SYNC;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_SYNC;
            addr_q          <= '0;
            row_q           <= '0;
            col_q           <= '0;
            rx_valid_prev_q <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            err_timeout_q   <= 1'b0;
            err_overrun_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            row_q           <= row_d;
            col_q           <= col_d;
            rx_valid_prev_q <= bus.rx_valid;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            err_timeout_q   <= err_timeout_d;
            err_overrun_q   <= err_overrun_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.busy        = (state_q == S_LOAD);
    assign bus.frame_ready = (state_q == S_DONE);
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_overrun = err_overrun_q;
endmodule

// File: tb/tb_uart_pixel_loader.sv
// Directed bench for uart_pixel_loader on a 4x2 image with a 50-cycle timeout.
module tb_uart_pixel_loader;
    import uart_pixel_loader_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int   wa[$];
    int   wd[$];
    int   to_cnt = 0;
    int   ov_cnt = 0;
    logic fr_at_last = 1'b0;

    uart_pixel_loader_if #(.ADDR_W(3), .RW_W(1), .CW_W(2)) bus ();

    uart_pixel_loader #(
        .IMG_W     (4),
        .IMG_H     (2),
        .SYNC_BYTE (8'hAA),
        .TIMEOUT   (50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log writes and error pulses mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                wa.push_back(int'(bus.wr_addr));
                wd.push_back(int'(bus.wr_data));
                if (bus.wr_addr == 3'd7) fr_at_last = bus.frame_ready;
            end
            if (bus.err_timeout) to_cnt++;
            if (bus.err_overrun) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        $display("tx byte %02h", b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.frame_ack = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_wr_en",       bus.wr_en,       0);
        check("rst_wr_addr",     bus.wr_addr,     0);
        check("rst_wr_data",     bus.wr_data,     0);
        check("rst_busy",        bus.busy,        0);
        check("rst_frame_ready", bus.frame_ready, 0);
        check("rst_err_timeout", bus.err_timeout, 0);
        check("rst_err_overrun", bus.err_overrun, 0);
        rst_n = 1'b1;
        tick();

        // Full frame: sync then 0x10..0x17
        send(8'hAA);
        check("a_busy", bus.busy, 1);
        bus.rx_byte  = 8'h10;
        bus.rx_valid = 1'b1;
        tick();
        check("a_lat_wr_en",   bus.wr_en,   1);
        check("a_lat_wr_addr", bus.wr_addr, 0);
        check("a_lat_wr_data", bus.wr_data, 8'h10);
        bus.rx_valid = 1'b0;
        tick();
        check("a_wr_en_single", bus.wr_en, 0);
        check("a_row_after1", bus.row, 0);
        check("a_col_after1", bus.col, 1);
        for (int i = 1; i < 8; i++) begin
            send(8'(8'h10 + i));
            if (i == 3) begin
                check("a_row_at4", bus.row, 1);
                check("a_col_at4", bus.col, 0);
            end
        end
        check("a_nwrites", wa.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("a_addr", wa[i], i);
            check("a_data", wd[i], 8'h10 + i);
        end
        check("a_fr_with_last", fr_at_last, 1);
        check("a_frame_ready", bus.frame_ready, 1);
        check("a_busy_done", bus.busy, 0);

        // Overruns in S_DONE, then ack coinciding with a sync-valued byte
        send(8'h01);
        send(8'h02);
        bus.rx_byte   = 8'hAA;
        bus.rx_valid  = 1'b1;
        bus.frame_ack = 1'b1;
        tick();
        bus.rx_valid  = 1'b0;
        bus.frame_ack = 1'b0;
        check("d_fr_after_ack", bus.frame_ready, 0);
        check("d_err_overrun_pulse", bus.err_overrun, 1);
        tick();
        check("d_busy_not_synced", bus.busy, 0);
        check("d_ov_cnt", ov_cnt, 3);
        check("d_no_writes", wa.size(), 8);

        // Non-sync bytes ignored, then one pixel
        wa.delete();
        wd.delete();
        send(8'h55);
        send(8'h01);
        check("b_no_write", wa.size(), 0);
        check("b_busy_idle", bus.busy, 0);
        send(8'hAA);
        send(8'h20);
        check("b_nwrites", wa.size(), 1);
        check("b_addr", wa[0], 0);
        check("b_data", wd[0], 8'h20);

        // Two more pixels then idle: timeout 50 cycles after last acceptance
        send(8'h21);
        send(8'h22);
        repeat (48) tick();
        check("c_busy_before_to", bus.busy, 1);
        check("c_no_to_yet", bus.err_timeout, 0);
        tick();
        check("c_busy_after_to", bus.busy, 0);
        check("c_err_timeout", bus.err_timeout, 1);
        tick();
        check("c_err_timeout_pulse", bus.err_timeout, 0);
        repeat (3) tick();
        check("c_to_cnt", to_cnt, 1);
        wa.delete();
        wd.delete();
        send(8'hAA);
        send(8'h30);
        check("c_restart_n", wa.size(), 1);
        check("c_restart_addr", wa[0], 0);
        check("c_restart_data", wd[0], 8'h30);

        // Strobe held high for five cycles counts once
        wa.delete();
        wd.delete();
        bus.rx_byte  = 8'h33;
        bus.rx_valid = 1'b1;
        repeat (5) tick();
        bus.rx_valid = 1'b0;
        repeat (2) tick();
        check("e_hold_n", wa.size(), 1);
        check("e_hold_addr", wa[0], 1);
        check("e_hold_data", wd[0], 8'h33);

        // Reset mid-frame with a byte about to be accepted
        wa.delete();
        bus.rx_byte  = 8'h44;
        bus.rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("r_wr_en",       bus.wr_en,       0);
        check("r_wr_addr",     bus.wr_addr,     0);
        check("r_wr_data",     bus.wr_data,     0);
        check("r_busy",        bus.busy,        0);
        check("r_frame_ready", bus.frame_ready, 0);
        check("r_err_timeout", bus.err_timeout, 0);
        check("r_err_overrun", bus.err_overrun, 0);
        check("r_row",         bus.row,         0);
        check("r_col",         bus.col,         0);
        check("r_state",       dut.state_q,     S_SYNC);
        tick();
        check("r_no_pending_wr", bus.wr_en, 0);
        check("r_no_log", wa.size(), 0);
        bus.rx_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
